// File: rtl/matrix_gen_3x3.sv
// Line-buffered 3x3 window generator: turns a raster pixel stream into three
// column vectors (top row in the MSBs) plus syncs, delayed 2 clocks.
module matrix_gen_3x3 #(
  parameter int P_IMG_WIDTH  = 640,
  parameter int P_DATA_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_h_sync,
  input  logic                      i_v_sync,
  input  logic [P_DATA_WIDTH-1:0]   i_pixel,
  output logic                      o_h_sync,
  output logic                      o_v_sync,
  output logic [3*P_DATA_WIDTH-1:0] o_raws_col1,
  output logic [3*P_DATA_WIDTH-1:0] o_raws_col2,
  output logic [3*P_DATA_WIDTH-1:0] o_raws_col3
);

  localparam int LP_CW = $clog2(P_IMG_WIDTH + 1);
  localparam int LP_AW = (P_IMG_WIDTH > 1) ? $clog2(P_IMG_WIDTH) : 1;
  localparam int LP_VW = 3 * P_DATA_WIDTH;
  localparam logic [LP_CW-1:0] LP_WIDTH = LP_CW'(P_IMG_WIDTH);

  // Line buffers: lb1 holds the previous line, lb2 the one before it.
  logic [P_DATA_WIDTH-1:0] lb1 [P_IMG_WIDTH];
  logic [P_DATA_WIDTH-1:0] lb2 [P_IMG_WIDTH];

  logic [LP_CW-1:0] colCnt_q, colCnt_d;
  logic [1:0]       rowCnt_q, rowCnt_d;
  logic             armed_q, armed_d;
  logic             hqPrev_q;

  logic [P_DATA_WIDTH-1:0] pix1_q;
  logic [LP_AW-1:0]        addr1_q;
  logic                    wr1_q, win1_q, first1_q, v1_q;

  logic [LP_VW-1:0] sh1_q, sh2_q, sh3_q;
  logic [LP_VW-1:0] sh1_d, sh2_d, sh3_d;
  logic [LP_VW-1:0] newVec;
  logic             oH_q, oV_q;

  logic hq;
  logic inRange;

  assign hq      = i_h_sync & i_v_sync;
  assign inRange = (colCnt_q < LP_WIDTH);
  assign newVec  = {lb2[addr1_q], lb1[addr1_q], pix1_q};

  always_comb begin
    colCnt_d = colCnt_q;
    rowCnt_d = rowCnt_q;
    armed_d  = armed_q | ~i_v_sync;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;
    sh3_d    = sh3_q;
    // Column saturates at the width so overlong lines cannot wrap into valid columns.
    if (!hq) begin
      colCnt_d = '0;
    end else if (colCnt_q != LP_WIDTH) begin
      colCnt_d = colCnt_q + LP_CW'(1);
    end
    if (!i_v_sync) begin
      rowCnt_d = '0;
    end else if (hqPrev_q && !hq && rowCnt_q != 2'd2) begin
      rowCnt_d = rowCnt_q + 2'd1;
    end
    // Left-edge zero padding: history is dropped on the first pixel of a line.
    if (wr1_q) begin
      sh3_d = newVec;
      sh2_d = first1_q ? '0 : sh3_q;
      sh1_d = first1_q ? '0 : sh2_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      colCnt_q <= '0;
      rowCnt_q <= '0;
      armed_q  <= 1'b0;
      hqPrev_q <= 1'b0;
      pix1_q   <= '0;
      addr1_q  <= '0;
      wr1_q    <= 1'b0;
      win1_q   <= 1'b0;
      first1_q <= 1'b0;
      v1_q     <= 1'b0;
      sh1_q    <= '0;
      sh2_q    <= '0;
      sh3_q    <= '0;
      oH_q     <= 1'b0;
      oV_q     <= 1'b0;
    end else begin
      colCnt_q <= colCnt_d;
      rowCnt_q <= rowCnt_d;
      armed_q  <= armed_d;
      hqPrev_q <= hq;
      pix1_q   <= i_pixel;
      addr1_q  <= colCnt_q[LP_AW-1:0];
      wr1_q    <= hq & inRange;
      win1_q   <= hq & inRange & (rowCnt_q == 2'd2) & armed_q;
      first1_q <= hq & (colCnt_q == '0);
      v1_q     <= i_v_sync & armed_q;
      sh1_q    <= sh1_d;
      sh2_q    <= sh2_d;
      sh3_q    <= sh3_d;
      oH_q     <= win1_q;
      oV_q     <= v1_q;
    end
  end

  // Buffer contents need no reset: they are only visible from row 2 of a frame.
  always_ff @(posedge i_clk) begin
    if (wr1_q) begin
      lb2[addr1_q] <= lb1[addr1_q];
      lb1[addr1_q] <= pix1_q;
    end
  end

  assign o_h_sync    = oH_q;
  assign o_v_sync    = oV_q;
  assign o_raws_col1 = oH_q ? sh1_q : '0;
  assign o_raws_col2 = oH_q ? sh2_q : '0;
  assign o_raws_col3 = oH_q ? sh3_q : '0;

endmodule

// File: tb/tb_matrix_gen_3x3.sv
// Bench for matrix_gen_3x3 with a 4-pixel line: directed frames plus random
// frames compared against a frame-image reference model.
module tb_matrix_gen_3x3;

  localparam int W = 4;

  logic        clock = 1'b0;
  logic        rst, hIn, vIn;
  logic [7:0]  pixIn;
  logic        oH, oV;
  logic [23:0] c1, c2, c3;

  always #5 clock = ~clock;

  matrix_gen_3x3 #(.P_IMG_WIDTH(W), .P_DATA_WIDTH(8)) dut (
    .i_clk(clock), .i_rst(rst), .i_h_sync(hIn), .i_v_sync(vIn), .i_pixel(pixIn),
    .o_h_sync(oH), .o_v_sync(oV),
    .o_raws_col1(c1), .o_raws_col2(c2), .o_raws_col3(c3)
  );

  typedef struct packed {
    logic        h;
    logic        v;
    logic [23:0] c1;
    logic [23:0] c2;
    logic [23:0] c3;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int failures = 0;
  int stepIdx = 0;

  // Reference model: pixels of the current frame indexed by (row, column).
  logic [7:0] img [64][W];
  bit mArmed, mPrevHq;
  int mRow, mCol;

  int pulseCnt, firstHStep, firstVStep, vRiseStep, row2Step;
  logic [23:0] cap1[$], cap2[$], cap3[$];

  task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h step=%0d", tag, obs, expv, stepIdx);
    end
  endtask

  function automatic logic [23:0] colVec(input int r, input int x);
    if (x < 0) return 24'h0;
    return {img[(r-2) & 63][x], img[(r-1) & 63][x], img[r & 63][x]};
  endfunction

  task automatic clearCapture();
    pulseCnt = 0;
    firstHStep = -1;
    firstVStep = -1;
    cap1.delete();
    cap2.delete();
    cap3.delete();
  endtask

  // One clock: check what the outputs show now, then drive the next input.
  task automatic applyStimulus(input bit r, input bit hh, input bit vv, input logic [7:0] p);
    exp_t e;
    bit hq;
    @(negedge clock);
    stepIdx++;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("o_h_sync", {23'd0, oH}, {23'd0, e.h});
      checkOutput("o_v_sync", {23'd0, oV}, {23'd0, e.v});
      checkOutput("col1", c1, e.c1);
      checkOutput("col2", c2, e.c2);
      checkOutput("col3", c3, e.c3);
      if (oH === 1'b1) begin
        pulseCnt++;
        cap1.push_back(c1);
        cap2.push_back(c2);
        cap3.push_back(c3);
        if (firstHStep < 0) firstHStep = stepIdx;
      end
      if (oV === 1'b1 && firstVStep < 0) firstVStep = stepIdx;
    end
    rst = r; hIn = hh; vIn = vv; pixIn = p;
    if (r) begin
      expQ.delete();
      expQ.push_back('0);
      expQ.push_back('0);
      mArmed = 0; mPrevHq = 0; mRow = 0; mCol = 0;
    end else begin
      e = '0;
      hq = hh && vv;
      e.v = vv && mArmed;
      if (hq) begin
        if (mCol < W) begin
          img[mRow & 63][mCol] = p;
          if (mRow >= 2 && mArmed) begin
            e.h  = 1'b1;
            e.c3 = colVec(mRow, mCol);
            e.c2 = colVec(mRow, mCol - 1);
            e.c1 = colVec(mRow, mCol - 2);
          end
        end
        mCol++;
      end else begin
        mCol = 0;
      end
      if (!vv) mRow = 0;
      else if (mPrevHq && !hq) mRow++;
      if (!vv) mArmed = 1;
      mPrevHq = hq;
      expQ.push_back(e);
    end
  endtask

  task automatic sendFrame(input int rows, input int base, input int longRow,
                           input int gap, input bit rnd);
    int len;
    logic [7:0] p;
    applyStimulus(0, 0, 1, 8'h00);
    vRiseStep = stepIdx;
    for (int r = 0; r < rows; r++) begin
      len = (r == longRow) ? W + 2 : W;
      for (int c = 0; c < len; c++) begin
        p = rnd ? 8'($urandom) : 8'(base + 16 * r + c);
        applyStimulus(0, 1, 1, p);
        if (r == 2 && c == 0) row2Step = stepIdx;
      end
      for (int g = 0; g < gap; g++) applyStimulus(0, 0, 1, 8'h00);
    end
  endtask

  task automatic vLow(input int n, input bit noisy);
    for (int i = 0; i < n; i++)
      applyStimulus(0, noisy ? 1'($urandom) : 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic checkBasicFrame(input string tag);
    checkOutput({tag, "_pulses"}, 24'(pulseCnt), 24'd8);
    if (cap3.size() >= 8) begin
      checkOutput({tag, "_w20_col3"}, cap3[0], 24'h001020);
      checkOutput({tag, "_w20_col2"}, cap2[0], 24'h000000);
      checkOutput({tag, "_w20_col1"}, cap1[0], 24'h000000);
      checkOutput({tag, "_w22_col1"}, cap1[2], 24'h001020);
      checkOutput({tag, "_w22_col2"}, cap2[2], 24'h011121);
      checkOutput({tag, "_w22_col3"}, cap3[2], 24'h021222);
      checkOutput({tag, "_w33_col3"}, cap3[7], 24'h132333);
    end
  endtask

  initial begin
    rst = 1'b1; hIn = 1'b0; vIn = 1'b0; pixIn = 8'h00;

    // Reset with random inputs, then release.
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1'($urandom), 1'($urandom), 8'($urandom));
    applyStimulus(0, 1'($urandom), 1'($urandom), 8'($urandom));
    applyStimulus(0, 1'($urandom), 1'($urandom), 8'($urandom));
    vLow(3, 0);

    // Basic 4x4 frame with latency checks.
    clearCapture();
    sendFrame(4, 0, -1, 2, 0);
    vLow(2, 0);
    checkBasicFrame("basic");
    checkOutput("h_latency", 24'(firstHStep - row2Step), 24'd2);
    checkOutput("v_latency", 24'(firstVStep - vRiseStep), 24'd2);

    // Overlong row 2: extra pixels must not wrap into columns 0 and 1.
    clearCapture();
    sendFrame(4, 8'h40, 2, 2, 0);
    vLow(2, 0);
    checkOutput("long_pulses", 24'(pulseCnt), 24'd8);
    if (cap3.size() >= 8) begin
      checkOutput("long_w30_col3", cap3[4], 24'h506070);
      checkOutput("long_w33_col1", cap1[7], 24'h516171);
      checkOutput("long_w33_col3", cap3[7], 24'h536373);
    end

    // Mid-frame start: reset released while a frame is running.
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 8'($urandom));
    clearCapture();
    sendFrame(3, 8'h20, -1, 2, 0);
    checkOutput("midframe_pulses", 24'(pulseCnt), 24'd0);
    vLow(2, 0);
    clearCapture();
    sendFrame(4, 0, -1, 2, 0);
    vLow(2, 0);
    checkBasicFrame("after_mid");

    // Back-to-back frames with a single-clock v gap and 1-clock h gaps.
    sendFrame(4, 8'h80, -1, 2, 0);
    vLow(1, 0);
    clearCapture();
    sendFrame(4, 0, -1, 1, 0);
    vLow(2, 0);
    checkBasicFrame("b2b");

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      sendFrame($urandom_range(6, 2), 0,
                ($urandom_range(1, 0) == 1) ? int'($urandom_range(5, 0)) : -1,
                $urandom_range(3, 1), 1);
      vLow($urandom_range(3, 1), 1);
    end

    // Reset in the middle of a windowed line.
    sendFrame(3, 0, -1, 1, 1);
    applyStimulus(0, 1, 1, 8'($urandom));
    applyStimulus(0, 1, 1, 8'($urandom));
    applyStimulus(1, 1, 1, 8'($urandom));
    clearCapture();
    applyStimulus(0, 1, 1, 8'($urandom));
    applyStimulus(0, 1, 1, 8'($urandom));
    applyStimulus(0, 0, 1, 8'h00);
    sendFrame(3, 8'h10, -1, 2, 0);
    checkOutput("post_reset_pulses", 24'(pulseCnt), 24'd0);
    vLow(2, 0);
    sendFrame(4, 0, -1, 2, 1);
    vLow(3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
